// File: rtl/olivia_pkg.sv
// Shared Olivia core types and constants used by the IF/ID fetch queue.
package olivia_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// IF->ID instruction queue: buffers {pc, instr} pairs across ID stalls,
// flushes on redirect and presents a NOP bubble when empty.
module fetch_queue
    import olivia_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("fetch_queue: DEPTH must be a power of two and >= 2");
    end

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fq_entry_t        r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Handshake is qualified only by occupancy, never by the other side.
    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Control state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data array carries no reset; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
        end
    end

    assign out_pc    = out_valid ? r_mem[r_rd_ptr].pc    : '0;
    assign out_instr = out_valid ? r_mem[r_rd_ptr].instr : NOP_INSTR;
    assign count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;
    import olivia_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [CNT_W-1:0]   count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_fail  = 0;
    fq_entry_t   model_q[$];
    logic [ADDR_W-1:0] next_pc = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the model says should be visible now.
    task automatic check_outputs();
        check("count", 64'(count), 64'(model_q.size()));
        check("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
        check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        if (model_q.size() == 0) begin
            check("out_pc_empty", out_pc, 64'(0));
            check("out_instr_empty", 64'(out_instr), 64'(NOP_INSTR));
        end else begin
            check("out_pc", out_pc, model_q[0].pc);
            check("out_instr", 64'(out_instr), 64'(model_q[0].instr));
        end
    endtask

    // One clock: drive, advance the model with the rules as sampled on the edge, check.
    task automatic step(input logic r, input logic fl, input logic iv, input logic ordy);
        bit push_ok;
        bit pop_ok;
        @(negedge clk);
        rst       = r;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = next_pc;
        in_instr  = 32'h8B020020 + INSTR_W'(next_pc >> 2);
        push_ok   = iv && (model_q.size() < DEPTH);
        pop_ok    = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) begin
                model_q.push_back('{pc: in_pc, instr: in_instr});
                next_pc = next_pc + 64'd4;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;

        // Reset held two cycles, then idle.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("reset_count", 64'(count), 64'(0));
        check("reset_instr", 64'(out_instr), 64'h00000000D503201F);

        // Fill to full, then a fifth push must be refused.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        check("full_count", 64'(count), 64'(4));
        check("full_head_pc", out_pc, 64'h0);

        // Drain in order.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        check("drained_valid", 64'(out_valid), 64'(0));

        // Steady state at count=2 with concurrent push/pop; pointers wrap.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
        check("steady_count", 64'(count), 64'(2));

        // Flush with count=3 and a push attempt in the same cycle.
        step(0, 0, 1, 0);
        check("pre_flush_count", 64'(count), 64'(3));
        step(0, 1, 1, 0);
        check("flush_count", 64'(count), 64'(0));
        step(0, 0, 0, 0);

        // Full queue: push+pop together pops only; push lands next cycle.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        check("full_pushpop_count", 64'(count), 64'(3));
        step(0, 0, 1, 0);
        check("refill_count", 64'(count), 64'(4));

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) == 0), ($urandom_range(19) == 0),
                 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
